// File: rtl/m_ram_arb2.sv
// m_ram_arb2: two-master arbiter in front of one single-port RAM slave.
// The grant is registered, and the grant state is also the one-hot GNT_O value.
// A master keeps the grant while it holds CYC. A burst limiter hands the RAM to
// a waiting master on an ACK edge, so a transfer is never split.
// The slave's ACK timing reaches the granted master unchanged. ACK is masked by
// the grant and by reset, so a stale read ACK is dropped.
module m_ram_arb2 #(
    parameter int ADRW     = 17,
    parameter int MAXBURST = 8,
    parameter bit M0_FIRST = 1'b1
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic            M0_CYC_I,
    input  logic            M0_STB_I,
    input  logic            M0_WE_I,
    input  logic [3:0]      M0_SEL_I,
    input  logic [ADRW-1:0] M0_ADR_I,
    input  logic [31:0]     M0_DAT_I,
    output logic            M0_ACK_O,
    input  logic            M1_CYC_I,
    input  logic            M1_STB_I,
    input  logic            M1_WE_I,
    input  logic [3:0]      M1_SEL_I,
    input  logic [ADRW-1:0] M1_ADR_I,
    input  logic [31:0]     M1_DAT_I,
    output logic            M1_ACK_O,
    output logic [31:0]     DAT_O,
    output logic            S_STB_O,
    output logic            S_WE_O,
    output logic [3:0]      S_SEL_O,
    output logic [ADRW-1:0] S_ADR_O,
    output logic [31:0]     S_DAT_O,
    input  logic [31:0]     S_DAT_I,
    input  logic            S_ACK_I,
    output logic [1:0]      GNT_O
);

    // state | meaning
    // IDLE  | nobody owns the RAM, arbitrate on CYC
    // G0    | M0 owns the RAM
    // G1    | M1 owns the RAM
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    localparam int BW = (MAXBURST < 1) ? 1 : $clog2(MAXBURST + 1);
    localparam logic [BW:0] MAXB = (BW + 1)'(MAXBURST);

    state_t        state_q, state_d;
    logic          lg_q;
    logic [BW-1:0] bcnt_q;
    logic [BW:0]   bcnt_inc;
    logic          burst_hit;
    logic          ack_en;

    assign bcnt_inc  = {1'b0, bcnt_q} + 1'b1;
    assign burst_hit = (MAXBURST != 0) && (bcnt_inc >= MAXB);
    assign ack_en    = S_ACK_I & ~RST_I;
    assign DAT_O     = S_DAT_I;
    assign GNT_O     = state_q;

    // Route the granted master to the slave and the slave's ACK back to it only.
    always_comb begin
        S_STB_O  = 1'b0;
        S_WE_O   = 1'b0;
        S_SEL_O  = '0;
        S_ADR_O  = '0;
        S_DAT_O  = '0;
        M0_ACK_O = 1'b0;
        M1_ACK_O = 1'b0;
        case (state_q)
            G0: begin
                S_STB_O  = M0_STB_I & M0_CYC_I & ~RST_I;
                S_WE_O   = M0_WE_I;
                S_SEL_O  = M0_SEL_I;
                S_ADR_O  = M0_ADR_I;
                S_DAT_O  = M0_DAT_I;
                M0_ACK_O = ack_en;
            end
            G1: begin
                S_STB_O  = M1_STB_I & M1_CYC_I & ~RST_I;
                S_WE_O   = M1_WE_I;
                S_SEL_O  = M1_SEL_I;
                S_ADR_O  = M1_ADR_I;
                S_DAT_O  = M1_DAT_I;
                M1_ACK_O = ack_en;
            end
            default: ;
        endcase
    end

    // Next grant: release first, then burst preemption on an ACK edge, else hold.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (M0_CYC_I && M1_CYC_I)
                    state_d = (M0_FIRST || lg_q) ? G0 : G1;
                else if (M0_CYC_I)
                    state_d = G0;
                else if (M1_CYC_I)
                    state_d = G1;
            end
            G0: begin
                if (!M0_CYC_I && !S_ACK_I)
                    state_d = M1_CYC_I ? G1 : IDLE;
                else if (S_ACK_I && M1_CYC_I && burst_hit)
                    state_d = G1;
            end
            G1: begin
                if (!M1_CYC_I && !S_ACK_I)
                    state_d = M0_CYC_I ? G0 : IDLE;
                else if (S_ACK_I && M0_CYC_I && burst_hit)
                    state_d = G0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant register, last-granted bit and saturating burst counter.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            lg_q    <= 1'b1;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                bcnt_q <= '0;
                if (state_d != IDLE)
                    lg_q <= (state_d == G1);
            end else if ((state_q != IDLE) && S_ACK_I && (bcnt_inc <= MAXB)) begin
                bcnt_q <= bcnt_inc[BW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_m_ram_arb2.sv
// Bench for m_ram_arb2. Instance 0 uses MAXBURST=8 and M0_FIRST=1.
// Instance 1 uses MAXBURST=0 and M0_FIRST=0.
// Each master transfer pushes its expected data into a per-master queue, and
// the monitor pops and compares on every ACK. Cycle probes arm the expected
// {M1_ACK, M0_ACK, S_STB, GNT} value for a given cycle, and the monitor checks it.
module tb_m_ram_arb2;
    localparam int ADRW = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst    [2];
    logic            m0_cyc [2];
    logic            m0_stb [2];
    logic            m0_we  [2];
    logic [3:0]      m0_sel [2];
    logic [ADRW-1:0] m0_adr [2];
    logic [31:0]     m0_dat [2];
    logic            m0_ack [2];
    logic            m1_cyc [2];
    logic            m1_stb [2];
    logic            m1_we  [2];
    logic [3:0]      m1_sel [2];
    logic [ADRW-1:0] m1_adr [2];
    logic [31:0]     m1_dat [2];
    logic            m1_ack [2];
    logic [31:0]     dat_o  [2];
    logic            s_stb  [2];
    logic            s_we   [2];
    logic [3:0]      s_sel  [2];
    logic [ADRW-1:0] s_adr  [2];
    logic [31:0]     s_dat_o[2];
    logic [31:0]     s_dat_i[2];
    logic            s_ack  [2];
    logic [1:0]      gnt    [2];

    m_ram_arb2 #(.ADRW(ADRW), .MAXBURST(8), .M0_FIRST(1'b1)) u_dut_a (
        .CLK_I(clk), .RST_I(rst[0]),
        .M0_CYC_I(m0_cyc[0]), .M0_STB_I(m0_stb[0]), .M0_WE_I(m0_we[0]), .M0_SEL_I(m0_sel[0]),
        .M0_ADR_I(m0_adr[0]), .M0_DAT_I(m0_dat[0]), .M0_ACK_O(m0_ack[0]),
        .M1_CYC_I(m1_cyc[0]), .M1_STB_I(m1_stb[0]), .M1_WE_I(m1_we[0]), .M1_SEL_I(m1_sel[0]),
        .M1_ADR_I(m1_adr[0]), .M1_DAT_I(m1_dat[0]), .M1_ACK_O(m1_ack[0]),
        .DAT_O(dat_o[0]), .S_STB_O(s_stb[0]), .S_WE_O(s_we[0]), .S_SEL_O(s_sel[0]),
        .S_ADR_O(s_adr[0]), .S_DAT_O(s_dat_o[0]), .S_DAT_I(s_dat_i[0]), .S_ACK_I(s_ack[0]),
        .GNT_O(gnt[0])
    );

    m_ram_arb2 #(.ADRW(ADRW), .MAXBURST(0), .M0_FIRST(1'b0)) u_dut_b (
        .CLK_I(clk), .RST_I(rst[1]),
        .M0_CYC_I(m0_cyc[1]), .M0_STB_I(m0_stb[1]), .M0_WE_I(m0_we[1]), .M0_SEL_I(m0_sel[1]),
        .M0_ADR_I(m0_adr[1]), .M0_DAT_I(m0_dat[1]), .M0_ACK_O(m0_ack[1]),
        .M1_CYC_I(m1_cyc[1]), .M1_STB_I(m1_stb[1]), .M1_WE_I(m1_we[1]), .M1_SEL_I(m1_sel[1]),
        .M1_ADR_I(m1_adr[1]), .M1_DAT_I(m1_dat[1]), .M1_ACK_O(m1_ack[1]),
        .DAT_O(dat_o[1]), .S_STB_O(s_stb[1]), .S_WE_O(s_we[1]), .S_SEL_O(s_sel[1]),
        .S_ADR_O(s_adr[1]), .S_DAT_O(s_dat_o[1]), .S_DAT_I(s_dat_i[1]), .S_ACK_I(s_ack[1]),
        .GNT_O(gnt[1])
    );

    // RAM model: combinational write ACK, registered read ACK and data.
    logic [31:0] mem [2][256];
    logic        rd_ack [2];
    logic        ram_init;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ram_init) begin
                for (int i = 0; i < 256; i++) mem[k][i] <= {24'h5AC300, i[7:0]};
                rd_ack[k]  <= 1'b0;
                s_dat_i[k] <= '0;
            end else begin
                if (s_stb[k] && s_we[k])
                    for (int b = 0; b < 4; b++)
                        if (s_sel[k][b]) mem[k][s_adr[k][7:0]][8*b +: 8] <= s_dat_o[k][8*b +: 8];
                rd_ack[k]  <= s_stb[k] && !s_we[k] && !rd_ack[k];
                s_dat_i[k] <= mem[k][s_adr[k][7:0]];
            end
        end
    end
    assign s_ack[0] = (s_stb[0] && s_we[0]) || rd_ack[0];
    assign s_ack[1] = (s_stb[1] && s_we[1]) || rd_ack[1];

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Scoreboard: {we, expected data}, one queue per instance/master.
    logic [32:0] q00[$], q01[$], q10[$], q11[$];
    int          n_run = 0;
    int          n_fail = 0;
    int          to_fail;
    logic        arm     [2];
    logic [4:0]  exp_prb [2];
    logic        done;

    task automatic sb_push(input int k, input int m, input logic [32:0] v);
        case ({k[0], m[0]})
            2'b00:   q00.push_back(v);
            2'b01:   q01.push_back(v);
            2'b10:   q10.push_back(v);
            default: q11.push_back(v);
        endcase
    endtask

    task automatic sb_check(input int k, input int m);
        logic [32:0] e;
        logic [32:0] act;
        logic        have;
        have = 1'b0;
        e    = '0;
        case ({k[0], m[0]})
            2'b00:   if (q00.size() > 0) begin e = q00.pop_front(); have = 1'b1; end
            2'b01:   if (q01.size() > 0) begin e = q01.pop_front(); have = 1'b1; end
            2'b10:   if (q10.size() > 0) begin e = q10.pop_front(); have = 1'b1; end
            default: if (q11.size() > 0) begin e = q11.pop_front(); have = 1'b1; end
        endcase
        n_run++;
        if (!have) begin
            n_fail++;
            $display("FAIL sb_ack inst%0d m%0d t=%0d: got unexpected ACK, want none", k, m, cyc_cnt);
        end else begin
            act = e[32] ? {s_we[k], s_dat_o[k]} : {s_we[k], dat_o[k]};
            if (act !== e) begin
                n_fail++;
                $display("FAIL sb_data inst%0d m%0d t=%0d: got we=%b data=%h, want we=%b data=%h",
                         k, m, cyc_cnt, act[32], act[31:0], e[32], e[31:0]);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (m0_ack[k] === 1'b1) sb_check(k, 0);
            if (m1_ack[k] === 1'b1) sb_check(k, 1);
            if (arm[k]) begin
                n_run++;
                if ({m1_ack[k], m0_ack[k], s_stb[k], gnt[k]} !== exp_prb[k]) begin
                    n_fail++;
                    $display("FAIL probe inst%0d t=%0d: got {ack1,ack0,stb,gnt}=%b, want %b",
                             k, cyc_cnt, {m1_ack[k], m0_ack[k], s_stb[k], gnt[k]}, exp_prb[k]);
                end
            end
        end
        if (done) begin
            n_run++;
            if (to_fail != 0) begin
                n_fail++;
                $display("FAIL timeouts: got %0d, want 0", to_fail);
            end
            n_run++;
            if ((q00.size() + q01.size() + q10.size() + q11.size()) != 0) begin
                n_fail++;
                $display("FAIL sb_leftover: got %0d pending, want 0",
                         q00.size() + q01.size() + q10.size() + q11.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
            $finish;
        end
    end

    task automatic drive(input int k, input int m, input logic cyc, input logic stb, input logic we,
                         input logic [ADRW-1:0] adr, input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc[k] = cyc; m0_stb[k] = stb; m0_we[k] = we;
            m0_sel[k] = 4'hF; m0_adr[k] = adr; m0_dat[k] = dat;
        end else begin
            m1_cyc[k] = cyc; m1_stb[k] = stb; m1_we[k] = we;
            m1_sel[k] = 4'hF; m1_adr[k] = adr; m1_dat[k] = dat;
        end
    endtask

    function automatic logic get_ack(input int k, input int m);
        return (m == 0) ? m0_ack[k] : m1_ack[k];
    endfunction

    // Back-to-back transfers under one CYC. For reads, dat0 is the expected read base.
    task automatic burst(input int k, input int m, input int n, input logic we,
                         input logic [ADRW-1:0] adr0, input logic [31:0] dat0);
        logic [ADRW-1:0] a;
        logic [31:0]     d;
        int              w;
        for (int i = 0; i < n; i++) begin
            a = adr0 + ADRW'(i);
            d = dat0 + 32'(i);
            drive(k, m, 1'b1, 1'b1, we, a, d);
            sb_push(k, m, {we, d});
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (get_ack(k, m) !== 1'b1 && w < 300);
            if (get_ack(k, m) !== 1'b1) begin
                to_fail++;
                $display("FAIL timeout inst%0d m%0d xfer %0d: got no ACK, want ACK within 300 cycles", k, m, i);
                drive(k, m, 1'b0, 1'b0, 1'b0, '0, '0);
                return;
            end
            @(posedge clk);
            #1;
        end
        drive(k, m, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_until(input int tgt);
        while (cyc_cnt < tgt) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe(input int k, input int tgt, input logic [4:0] e);
        wait_until(tgt);
        exp_prb[k] = e;
        arm[k]     = 1'b1;
        @(negedge clk);
        #1;
        arm[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before 100000 time units");
        $fatal(1, "watchdog");
    end

    int t0;
    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1;
            arm[k] = 1'b0;
            exp_prb[k] = '0;
            drive(k, 0, 1'b0, 1'b0, 1'b0, '0, '0);
            drive(k, 1, 1'b0, 1'b0, 1'b0, '0, '0);
        end
        done     = 1'b0;
        to_fail  = 0;
        ram_init = 1'b1;
        idle(3);
        probe(0, cyc_cnt, 5'b00000);
        probe(1, cyc_cnt, 5'b00000);
        idle(1);
        rst[0]   = 1'b0;
        rst[1]   = 1'b0;
        ram_init = 1'b0;
        idle(2);

        // Instance 0: single M0 write
        t0 = cyc_cnt;
        fork
            burst(0, 0, 1, 1'b1, 17'h00010, 32'hDEADBEEF);
            begin
                probe(0, t0,     5'b00000);
                probe(0, t0 + 1, 5'b01101);
                probe(0, t0 + 2, 5'b00001);
                probe(0, t0 + 3, 5'b00000);
            end
        join
        idle(3);

        // Instance 0: simultaneous reads, M0 first, direct handover to M1
        t0 = cyc_cnt;
        fork
            burst(0, 0, 1, 1'b0, 17'h00010, 32'hDEADBEEF);
            burst(0, 1, 1, 1'b0, 17'h00020, 32'h5AC30020);
            begin
                probe(0, t0,     5'b00000);
                probe(0, t0 + 1, 5'b00101);
                probe(0, t0 + 2, 5'b01101);
                probe(0, t0 + 3, 5'b00001);
                probe(0, t0 + 4, 5'b00110);
                probe(0, t0 + 5, 5'b10110);
                probe(0, t0 + 6, 5'b00010);
                probe(0, t0 + 7, 5'b00000);
            end
        join
        idle(3);

        // Instance 0: M0 20-read burst preempted at its 8th ACK by waiting M1
        t0 = cyc_cnt;
        fork
            burst(0, 0, 20, 1'b0, 17'h00040, 32'h5AC30040);
            burst(0, 1, 2,  1'b0, 17'h00080, 32'h5AC30080);
            begin
                probe(0, t0,      5'b00000);
                probe(0, t0 + 1,  5'b00101);
                probe(0, t0 + 16, 5'b01101);
                probe(0, t0 + 17, 5'b00110);
                probe(0, t0 + 18, 5'b10110);
                probe(0, t0 + 21, 5'b00010);
                probe(0, t0 + 22, 5'b00101);
                probe(0, t0 + 23, 5'b01101);
            end
        join
        idle(3);

        // Instance 0: reset while a read ACK is due; ACK is dropped, M0 re-requests
        t0 = cyc_cnt;
        fork
            burst(0, 0, 1, 1'b0, 17'h00030, 32'h5AC30030);
            begin
                probe(0, t0 + 1, 5'b00101);
                wait_until(t0 + 2);
                rst[0] = 1'b1;
                probe(0, t0 + 2, 5'b00001);
                wait_until(t0 + 3);
                rst[0] = 1'b0;
                probe(0, t0 + 3, 5'b00000);
                probe(0, t0 + 4, 5'b00101);
                probe(0, t0 + 5, 5'b01101);
            end
        join
        idle(3);

        // Instance 1: both request, M0 wins on lg; M1 withdraws so lg becomes M0
        t0 = cyc_cnt;
        fork
            burst(1, 0, 1, 1'b1, 17'h00005, 32'h11110005);
            begin
                drive(1, 1, 1'b1, 1'b1, 1'b1, 17'h00006, 32'h22220006);
                idle(1);
                drive(1, 1, 1'b0, 1'b0, 1'b0, '0, '0);
            end
            begin
                probe(1, t0,     5'b00000);
                probe(1, t0 + 1, 5'b01101);
                probe(1, t0 + 2, 5'b00001);
                probe(1, t0 + 3, 5'b00000);
            end
        join
        idle(3);

        // Instance 1: both request again, M1 now wins
        t0 = cyc_cnt;
        fork
            burst(1, 0, 1, 1'b1, 17'h00007, 32'h33330007);
            burst(1, 1, 1, 1'b1, 17'h00008, 32'h44440008);
            begin
                probe(1, t0,     5'b00000);
                probe(1, t0 + 1, 5'b10110);
                probe(1, t0 + 2, 5'b00010);
                probe(1, t0 + 3, 5'b01101);
                probe(1, t0 + 4, 5'b00001);
            end
        join
        idle(3);

        // Instance 1: unlimited burst, M1 writes 100 words while M0 waits
        t0 = cyc_cnt;
        fork
            burst(1, 1, 100, 1'b1, 17'h00100, 32'hC0DE0000);
            burst(1, 0, 1,   1'b1, 17'h00180, 32'h55550180);
            begin
                probe(1, t0 + 1,   5'b10110);
                probe(1, t0 + 50,  5'b10110);
                probe(1, t0 + 100, 5'b10110);
                probe(1, t0 + 101, 5'b00010);
                probe(1, t0 + 102, 5'b01101);
            end
        join
        idle(3);

        done = 1'b1;
        idle(4);
    end

endmodule
